// File: rtl/weight_fetch_ctrl.sv
// Weight fetch controller: streams 'count' words per channel from three
// parallel weight ROMs (1-cycle registered read) into a valid/ready
// handshake toward the convolution datapath. Reads are only issued when the
// single-entry output stage can accept them, so under backpressure the ROM
// output registers themselves hold the pending word.
module weight_fetch_ctrl #(
    parameter int ROM_ADDR_BITS = 10,
    parameter int ROM_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ROM_ADDR_BITS-1:0] base_addr,
    input  logic [ROM_ADDR_BITS:0]   count,
    input  logic [2:0]               ch_mask,
    input  logic                     abort,
    output logic                     rom_en   [0:2],
    output logic [ROM_ADDR_BITS-1:0] rom_addr [0:2],
    input  logic [ROM_WIDTH-1:0]     rom_data [0:2],
    output logic [ROM_WIDTH-1:0]     w_data   [0:2],
    output logic                     w_valid,
    input  logic                     w_ready,
    output logic                     w_last,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    localparam logic [ROM_ADDR_BITS:0] MAX_COUNT = {1'b1, {ROM_ADDR_BITS{1'b0}}};
    localparam logic [ROM_ADDR_BITS:0] ONE_LEFT  = {{ROM_ADDR_BITS{1'b0}}, 1'b1};

    state_t                   state_q, state_d;
    logic [ROM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [ROM_ADDR_BITS:0]   remaining_q, remaining_d;
    logic [2:0]               mask_q, mask_d;
    logic                     valid_q, valid_d;
    logic                     last_q, last_d;
    logic                     err_q, err_d;
    logic                     errPulse_q, errPulse_d;

    logic countOk;
    logic issue;
    logic lastHandshake;

    assign countOk       = (count != '0) && (count <= MAX_COUNT);
    assign issue         = (state_q == FETCH) && (remaining_q != '0) && (!valid_q || w_ready);
    assign lastHandshake = (state_q == DRAIN) && valid_q && last_q && w_ready;

    // Next-state logic: output-stage bookkeeping first, then job control (abort beats start).
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        mask_d      = mask_q;
        valid_d     = valid_q;
        last_d      = last_q;
        err_d       = err_q;
        errPulse_d  = 1'b0;

        if (issue) begin
            addr_d      = addr_q + 1'b1;
            remaining_d = remaining_q - ONE_LEFT;
            valid_d     = 1'b1;
            last_d      = (remaining_q == ONE_LEFT);
        end else if (valid_q && w_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (countOk) begin
                        state_d     = FETCH;
                        addr_d      = base_addr;
                        remaining_d = count;
                        mask_d      = ch_mask;
                        err_d       = 1'b0;
                    end else begin
                        err_d      = 1'b1;
                        errPulse_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (abort) begin
                    state_d     = IDLE;
                    valid_d     = 1'b0;
                    last_d      = 1'b0;
                    remaining_d = '0;
                end else if (issue && (remaining_q == ONE_LEFT)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d     = IDLE;
                    valid_d     = 1'b0;
                    last_d      = 1'b0;
                    remaining_d = '0;
                end else if (lastHandshake) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            mask_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            errPulse_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            mask_q      <= mask_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            err_q       <= err_d;
            errPulse_q  <= errPulse_d;
        end
    end

    // Per-channel ROM controls and the pass-through weight stream.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rom_en[i]   = issue && mask_q[i] && !rst;
            rom_addr[i] = addr_q;
            w_data[i]   = rom_data[i];
        end
    end

    assign w_valid = valid_q;
    assign w_last  = last_q;
    assign busy    = (state_q != IDLE);
    assign err     = err_q;
    assign done    = !rst && (errPulse_q || (lastHandshake && !abort));

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Self-checking bench for weight_fetch_ctrl. A behavioural ROM model sits on
// the ROM ports; each job is checked against the expected beat sequence
// (base+k per beat, last on beat count-1) tracked as issued/delivered totals.
module tb_weight_fetch_ctrl;

    localparam int AB = 10;
    localparam int CW = AB + 1;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AB-1:0] base_addr;
    logic [CW-1:0] count;
    logic [2:0]    ch_mask;
    logic          abort;
    logic          rom_en   [0:2];
    logic [AB-1:0] rom_addr [0:2];
    logic [DW-1:0] rom_data [0:2];
    logic [DW-1:0] w_data   [0:2];
    logic          w_valid;
    logic          w_ready;
    logic          w_last;
    logic          busy;
    logic          done;
    logic          err;

    int nChecks = 0;
    int nPassed = 0;

    weight_fetch_ctrl #(.ROM_ADDR_BITS(AB), .ROM_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .ch_mask(ch_mask), .abort(abort), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .w_last(w_last), .busy(busy), .done(done), .err(err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] romWord(input int ch, input logic [AB-1:0] a);
        return 16'(ch * 4099 + int'(a) * 37 + 23130);
    endfunction

    // Registered ROM model: one-cycle latency, holds its word when not enabled.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            if (rom_en[i]) rom_data[i] <= romWord(i, rom_addr[i]);
    end

    function automatic logic [2:0] enVec();
        return {rom_en[2], rom_en[1], rom_en[0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed === expected) nPassed++;
        else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // Runs one job from the start cycle (cycle 0) to completion or kill.
    task automatic applyStimulus(input logic [AB-1:0] b, input int cnt, input logic [2:0] m,
                                 input int readyPct, input logic [31:0] stallCyc,
                                 input int abortCyc, input int rstCyc, input int extraCyc);
        int issues = 0;
        int beats = 0;
        int doneCyc = -1;
        int limit;
        bit finished = 0;
        bit killed = 0;
        bit sawIssue, expIssue;
        logic [AB-1:0] expAddr, beatAddr;

        start = 1'b1; base_addr = b; count = CW'(cnt); ch_mask = m; abort = 1'b0; rst = 1'b0;
        w_ready = ($urandom_range(99) < readyPct);
        @(negedge clk);
        checkOutput("startBusy", busy, 0);
        checkOutput("startEn", enVec(), 0);
        @(posedge clk); #1;
        start = 1'b0;
        limit = 10 * cnt + 50;
        for (int c = 1; c <= limit && !finished && !killed; c++) begin
            w_ready = ((c < 32) && stallCyc[c[4:0]]) ? 1'b0 : ($urandom_range(99) < readyPct);
            abort = (c == abortCyc);
            rst = (c == rstCyc);
            if (c == extraCyc) begin
                start = 1'b1;
                base_addr = AB'($urandom);
                count = CW'($urandom_range(8, 1));
                ch_mask = 3'($urandom_range(7, 1));
            end
            @(negedge clk);
            if (c == 1) checkOutput("errCleared", err, 0);
            if (abort || rst) begin
                checkOutput("killDone", done, 0);
                killed = 1;
            end else begin
                expIssue = (issues < cnt) && (!w_valid || w_ready);
                sawIssue = (enVec() != 3'b000);
                checkOutput("issue", sawIssue, expIssue);
                checkOutput("busy", busy, 1);
                checkOutput("valid", w_valid, (issues > beats));
                if (sawIssue) begin
                    expAddr = b + AB'(issues);
                    checkOutput("en", enVec(), m);
                    for (int i = 0; i < 3; i++) checkOutput("addr", rom_addr[i], expAddr);
                end
                if (w_valid) begin
                    beatAddr = b + AB'(beats);
                    checkOutput("last", w_last, (beats == cnt - 1));
                    for (int i = 0; i < 3; i++)
                        if (m[i]) checkOutput("data", w_data[i], romWord(i, beatAddr));
                end
                if (w_valid && w_ready) begin
                    checkOutput("done", done, (beats == cnt - 1));
                    beats++;
                    if (beats == cnt) begin
                        finished = 1;
                        doneCyc = c;
                    end
                end else begin
                    checkOutput("doneIdle", done, 0);
                end
                if (sawIssue) issues++;
            end
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0; rst = 1'b0;
        end

        @(negedge clk);
        if (killed) begin
            checkOutput("killBusy", busy, 0);
            checkOutput("killValid", w_valid, 0);
            checkOutput("killLast", w_last, 0);
            checkOutput("killEn", enVec(), 0);
            checkOutput("killDoneAfter", done, 0);
            if (rstCyc > 0) begin
                checkOutput("rstErr", err, 0);
                for (int i = 0; i < 3; i++) checkOutput("rstAddr", rom_addr[i], 0);
            end
        end else begin
            checkOutput("beatsDelivered", beats, cnt);
            checkOutput("issueTotal", issues, cnt);
            checkOutput("endBusy", busy, 0);
            checkOutput("endValid", w_valid, 0);
            checkOutput("endDone", done, 0);
            if (readyPct == 100 && stallCyc == 0) checkOutput("latency", doneCyc, cnt + 1);
        end
        @(posedge clk); #1;
    endtask

    // A start with an out-of-range count: err set, one done pulse, no reads.
    task automatic applyBadStart(input int cnt);
        start = 1'b1; count = CW'(cnt); base_addr = AB'($urandom); ch_mask = 3'b111; w_ready = 1'b1;
        @(negedge clk);
        checkOutput("badDoneEarly", done, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("badErr", err, 1);
        checkOutput("badDone", done, 1);
        checkOutput("badBusy", busy, 0);
        checkOutput("badEn", enVec(), 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("badErrSticky", err, 1);
        checkOutput("badDoneOnce", done, 0);
        checkOutput("badEnLater", enVec(), 0);
        @(posedge clk); #1;
    endtask

    // Main sequence: reset, directed scenarios, then randomized jobs.
    initial begin
        int cnt, pctSel, pct, ab, ex;
        rst = 1'b1; start = 1'b0; abort = 1'b0; w_ready = 1'b0;
        base_addr = '0; count = '0; ch_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstErr0", err, 0);
        checkOutput("rstValid", w_valid, 0);
        checkOutput("rstLast", w_last, 0);
        checkOutput("rstEn0", enVec(), 0);
        for (int i = 0; i < 3; i++) checkOutput("rstAddr0", rom_addr[i], 0);
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus(10'h010, 4, 3'b111, 100, 32'h0, -1, -1, -1);
        applyStimulus(10'h010, 4, 3'b111, 100, 32'b11100, -1, -1, -1);
        applyStimulus(10'h3FE, 4, 3'b101, 100, 32'h0, -1, -1, -1);
        applyBadStart(0);
        applyBadStart(1025);
        applyBadStart(2047);
        applyStimulus(10'h123, 1, 3'b010, 100, 32'h0, -1, -1, -1);
        applyStimulus(10'h020, 8, 3'b111, 100, 32'h0, 4, -1, -1);
        applyStimulus(10'h040, 8, 3'b111, 100, 32'h0, -1, 5, -1);
        applyStimulus(10'h050, 6, 3'b011, 100, 32'h0, -1, -1, 3);
        applyStimulus(10'h060, 5, 3'b110, 100, 32'h0, -1, -1, 6);
        applyStimulus(AB'($urandom), 1024, 3'b111, 100, 32'h0, -1, -1, -1);

        for (int j = 0; j < 25; j++) begin
            cnt = $urandom_range(12, 1);
            pctSel = $urandom_range(2);
            pct = (pctSel == 0) ? 100 : ((pctSel == 1) ? 75 : 40);
            ab = ($urandom_range(4) == 0) ? $urandom_range(cnt + 1, 1) : -1;
            ex = ($urandom_range(2) == 0) ? $urandom_range(cnt + 2, 1) : -1;
            applyStimulus(AB'($urandom), cnt, 3'($urandom_range(7, 1)), pct, 32'h0, ab, -1, ex);
        end

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
